csi_rx_pkt_depacketizer: RTL and testbench

Parametrised successor to the current single-VC CSI-2 packet handler, supporting 1, 2 or 4 lanes. Sits between the word aligner and the pixel unpacker in the CSI receive path. Assembles and ECC-checks packet headers, tracks frame and line state, and forwards long-packet payload with per-byte enables. Adds virtual-channel selection, a word-count limit, header-error reporting and frame/line numbering.

---
 rtl/csi_rx_pkt_depacketizer_if.sv | 24 ++
 rtl/csi_rx_pkt_depacketizer.sv | 194 +++++++++++++++++++
 tb/tb_csi_rx_pkt_depacketizer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csi_rx_pkt_depacketizer_if.sv
// Beat bus between the word aligner, the packet depacketizer and the pixel unpacker.
// slave is the depacketizer; master is the surrounding aligner/unpacker side.
interface csi_rx_pkt_depacketizer_if #(
  parameter int unsigned NUM_LANE = 2
);
  logic [NUM_LANE*8-1:0] data;
  logic                  data_valid;
  logic                  sync_wait;
  logic                  packet_done;
  logic [NUM_LANE*8-1:0] payload_out;
  logic                  payload_valid;
  logic [NUM_LANE-1:0]   payload_be;
  logic                  payload_last;

  modport master (
    output data, data_valid,
    input  sync_wait, packet_done, payload_out, payload_valid, payload_be, payload_last
  );

  modport slave (
    input  data, data_valid,
    output sync_wait, packet_done, payload_out, payload_valid, payload_be, payload_last
  );
endinterface

// File: rtl/csi_rx_pkt_depacketizer.sv
// CSI-2 packet depacketizer: header assembly and ECC check, frame/line tracking and
// forwarding of RAW long-packet payload on one virtual channel with byte enables.
module csi_rx_pkt_depacketizer #(
  parameter int unsigned NUM_LANE = 2,
  parameter logic [1:0]  VC_SEL   = 2'd0,
  parameter logic [15:0] MAX_WC   = 16'd8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  csi_rx_pkt_depacketizer_if.slave bus,
  output logic        in_frame,
  output logic        in_line,
  output logic [15:0] frame_num,
  output logic [15:0] line_num,
  output logic        hdr_err
);

  localparam int unsigned W = NUM_LANE * 8;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StHdr     = 3'd1;
  localparam logic [2:0] StPayload = 3'd2;
  localparam logic [2:0] StDone    = 3'd3;
  localparam logic [2:0] StStop    = 3'd4;

  // Hamming code over the 24 header bits; each mask selects the bits feeding one parity bit.
  function automatic logic [7:0] csi_rx_hdr_ecc(input logic [23:0] d);
    logic [7:0] p;
    p    = '0;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  logic [2:0]          state_q;
  logic [1:0]          cnt_q;
  logic [31:0]         hdr_q;
  logic [15:0]         rem_q;
  logic                fwd_q;
  logic [W-1:0]        pay_data_q;
  logic                pay_valid_q;
  logic [NUM_LANE-1:0] pay_be_q;
  logic                pay_last_q;
  logic                in_frame_q;
  logic                in_line_q;
  logic [15:0]         frame_num_q;
  logic [15:0]         line_num_q;
  logic                hdr_err_q;

  logic [31:0]         hdr_cur;
  logic [1:0]          pos;
  logic                hdr_final;
  logic [1:0]          vc;
  logic [5:0]          dt;
  logic [15:0]         wc;
  logic                dt_ok;
  logic                is_short;
  logic                hdr_ok;
  logic                raw_dt;
  logic                vc_hit;
  logic                is_last;
  logic [NUM_LANE-1:0] last_be;

  // Merge the current beat into the bytes collected so far.
  always_comb begin
    hdr_cur = hdr_q;
    pos     = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      pos = cnt_q + 2'(i);
      hdr_cur[{pos, 3'b000} +: 8] = bus.data[i*8 +: 8];
    end
  end

  assign hdr_final = ({1'b0, cnt_q} + 3'(NUM_LANE)) == 3'd4;
  assign vc        = hdr_cur[7:6];
  assign dt        = hdr_cur[5:0];
  assign wc        = hdr_cur[23:8];
  assign dt_ok     = (dt <= 6'h03) || (dt >= 6'h10 && dt <= 6'h12) ||
                     (dt >= 6'h28 && dt <= 6'h2D);
  assign is_short  = dt < 6'h10;
  assign hdr_ok    = (hdr_cur[31:24] == csi_rx_hdr_ecc(hdr_cur[23:0])) && dt_ok &&
                     (is_short || wc <= MAX_WC);
  assign raw_dt    = dt >= 6'h28 && dt <= 6'h2D;
  assign vc_hit    = vc == VC_SEL;
  assign is_last   = rem_q <= 16'(NUM_LANE);

  always_comb begin
    last_be = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      last_be[i] = 16'(i) < rem_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hdr_q       <= '0;
      rem_q       <= '0;
      fwd_q       <= 1'b0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_be_q    <= '0;
      pay_last_q  <= 1'b0;
      in_frame_q  <= 1'b0;
      in_line_q   <= 1'b0;
      frame_num_q <= '0;
      line_num_q  <= '0;
      hdr_err_q   <= 1'b0;
    end else if (enable) begin
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_be_q    <= '0;
      pay_last_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      case (state_q)
        StIdle, StHdr: begin
          if (bus.data_valid) begin
            hdr_q <= hdr_cur;
            if (!hdr_final) begin
              cnt_q   <= cnt_q + 2'(NUM_LANE);
              state_q <= StHdr;
            end else begin
              cnt_q <= '0;
              // fwd drops on anything but a valid long header so DONE never counts a stale line.
              if (!hdr_ok) begin
                hdr_err_q <= 1'b1;
                fwd_q     <= 1'b0;
                state_q   <= StDone;
              end else if (is_short) begin
                fwd_q   <= 1'b0;
                state_q <= StDone;
                if (vc_hit && dt == 6'h00) begin
                  in_frame_q  <= 1'b1;
                  frame_num_q <= wc;
                  line_num_q  <= '0;
                end else if (vc_hit && dt == 6'h01) begin
                  in_frame_q <= 1'b0;
                end
              end else begin
                fwd_q     <= vc_hit && raw_dt;
                in_line_q <= vc_hit && raw_dt;
                rem_q     <= wc;
                state_q   <= (wc == 16'd0) ? StDone : StPayload;
              end
            end
          end
        end
        StPayload: begin
          if (bus.data_valid) begin
            if (fwd_q) begin
              pay_data_q  <= bus.data;
              pay_valid_q <= 1'b1;
              pay_be_q    <= is_last ? last_be : '1;
              pay_last_q  <= is_last;
            end
            if (is_last) begin
              state_q <= StDone;
            end else begin
              rem_q <= rem_q - 16'(NUM_LANE);
            end
          end
        end
        StDone: begin
          in_line_q <= 1'b0;
          if (fwd_q && in_frame_q && line_num_q != 16'hFFFF) begin
            line_num_q <= line_num_q + 16'd1;
          end
          state_q <= StStop;
        end
        StStop:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sync_wait     = state_q == StIdle;
  assign bus.packet_done   = state_q == StDone;
  assign bus.payload_out   = pay_data_q;
  assign bus.payload_valid = pay_valid_q;
  assign bus.payload_be    = pay_be_q;
  assign bus.payload_last  = pay_last_q;
  assign in_frame          = in_frame_q;
  assign in_line           = in_line_q;
  assign frame_num         = frame_num_q;
  assign line_num          = line_num_q;
  assign hdr_err           = hdr_err_q;

endmodule

// File: tb/tb_csi_rx_pkt_depacketizer.sv
// Bench for csi_rx_pkt_depacketizer: a 2-lane (VC_SEL=0) and a 4-lane (VC_SEL=1) instance
// driven by directed and random packets and compared against a packet-level model.
module tb_csi_rx_pkt_depacketizer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] drv_data;
  logic        drv_valid;
  int          sel;

  int n_asrt;
  int n_fail;

  csi_rx_pkt_depacketizer_if #(.NUM_LANE(2)) bus2 ();
  csi_rx_pkt_depacketizer_if #(.NUM_LANE(4)) bus4 ();

  logic        if2, il2, he2, if4, il4, he4;
  logic [15:0] fn2, ln2, fn4, ln4;

  assign bus2.data       = drv_data[15:0];
  assign bus2.data_valid = drv_valid && (sel == 2);
  assign bus4.data       = drv_data;
  assign bus4.data_valid = drv_valid && (sel == 4);

  csi_rx_pkt_depacketizer #(.NUM_LANE(2), .VC_SEL(2'd0), .MAX_WC(16'd8192)) u_dut2 (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus2),
    .in_frame  (if2),
    .in_line   (il2),
    .frame_num (fn2),
    .line_num  (ln2),
    .hdr_err   (he2)
  );

  csi_rx_pkt_depacketizer #(.NUM_LANE(4), .VC_SEL(2'd1), .MAX_WC(16'd8192)) u_dut4 (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus4),
    .in_frame  (if4),
    .in_line   (il4),
    .frame_num (fn4),
    .line_num  (ln4),
    .hdr_err   (he4)
  );

  logic [31:0] o_sync, o_done, o_pv, o_pout, o_pbe, o_plast, o_inf, o_inl, o_fn, o_ln, o_herr;
  assign o_sync  = 32'((sel == 2) ? bus2.sync_wait : bus4.sync_wait);
  assign o_done  = 32'((sel == 2) ? bus2.packet_done : bus4.packet_done);
  assign o_pv    = 32'((sel == 2) ? bus2.payload_valid : bus4.payload_valid);
  assign o_pout  = (sel == 2) ? {16'h0, bus2.payload_out} : bus4.payload_out;
  assign o_pbe   = (sel == 2) ? {30'h0, bus2.payload_be} : {28'h0, bus4.payload_be};
  assign o_plast = 32'((sel == 2) ? bus2.payload_last : bus4.payload_last);
  assign o_inf   = 32'((sel == 2) ? if2 : if4);
  assign o_inl   = 32'((sel == 2) ? il2 : il4);
  assign o_fn    = 32'((sel == 2) ? fn2 : fn4);
  assign o_ln    = 32'((sel == 2) ? ln2 : ln4);
  assign o_herr  = 32'((sel == 2) ? he2 : he4);

  // Packet-level model state, index 0 = 2-lane instance, 1 = 4-lane instance.
  bit          m_if [2];
  logic [15:0] m_fn [2];
  logic [15:0] m_ln [2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: observed no end of test, expected $finish");
    $fatal(1);
  end

  // Syndrome of each header bit D0..D23; the ECC is the XOR of syndromes of the set bits.
  function automatic logic [7:0] ref_ecc(input logic [23:0] d);
    logic [5:0] syn [24];
    logic [7:0] e;
    syn = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
            6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ {2'b00, syn[i]};
    return e;
  endfunction

  function automatic bit dt_legal(input logic [5:0] dt);
    return dt inside {[6'h00:6'h03], [6'h10:6'h12], [6'h28:6'h2D]};
  endfunction

  function automatic logic [31:0] bmask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic v);
    drv_data  = d;
    drv_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sync"}, o_sync, 32'd1);
    chk({tag, "_done"}, o_done, 32'd0);
    chk({tag, "_pv"}, o_pv, 32'd0);
    chk({tag, "_pout"}, o_pout, 32'd0);
    chk({tag, "_pbe"}, o_pbe, 32'd0);
    chk({tag, "_plast"}, o_plast, 32'd0);
    chk({tag, "_inf"}, o_inf, 32'd0);
    chk({tag, "_inl"}, o_inl, 32'd0);
    chk({tag, "_fn"}, o_fn, 32'd0);
    chk({tag, "_ln"}, o_ln, 32'd0);
    chk({tag, "_herr"}, o_herr, 32'd0);
  endtask

  task automatic beat_chk(input logic [31:0] pv, input logic [31:0] pd, input logic [31:0] msk,
                          input logic [31:0] be, input logic [31:0] last,
                          input logic [31:0] done, input logic [31:0] inl);
    chk("pay_valid", o_pv, pv);
    chk("pay_data", o_pout & msk, pd);
    chk("pay_be", o_pbe, be);
    chk("pay_last", o_plast, last);
    chk("pay_done", o_done, done);
    chk("pay_in_line", o_inl, inl);
  endtask

  task automatic send_pkt(input int nl, input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input bit bad_ecc, input int freeze_at);
    int          ci;
    logic [1:0]  vcsel;
    logic [7:0]  h [4];
    logic [31:0] d, msk, exp_d;
    logic [3:0]  exp_be;
    bit          ok, long_pkt, fwd, last;
    int          nbeats, cnt;
    sel   = nl;
    ci    = (nl == 2) ? 0 : 1;
    vcsel = 2'(ci);
    h[0]  = {vc, dt};
    h[1]  = wc[7:0];
    h[2]  = wc[15:8];
    h[3]  = ref_ecc({h[2], h[1], h[0]});
    if (bad_ecc) h[3] = h[3] ^ (8'd1 << $urandom_range(7, 0));
    ok       = !bad_ecc && dt_legal(dt) && (dt < 6'h10 || wc <= 16'd8192);
    long_pkt = dt >= 6'h10;
    fwd      = ok && long_pkt && vc == vcsel && dt >= 6'h28 && dt <= 6'h2D;
    chk("idle_sync", o_sync, 32'd1);
    for (int b = 0; b < 4; b += nl) begin
      if (b > 0 && $urandom_range(3, 0) == 0) begin
        drive($urandom, 1'b0);
        chk("hdr_stall_done", o_done, 32'd0);
      end
      d = '0;
      for (int j = 0; j < nl; j++) d[j*8 +: 8] = h[b+j];
      drive(d, 1'b1);
      if (b + nl < 4) chk("hdr_mid_done", o_done, 32'd0);
    end
    if (ok && !long_pkt && vc == vcsel) begin
      if (dt == 6'h00) begin
        m_if[ci] = 1'b1;
        m_fn[ci] = wc;
        m_ln[ci] = '0;
      end else if (dt == 6'h01) begin
        m_if[ci] = 1'b0;
      end
    end
    chk("hdr_err", o_herr, 32'(!ok));
    chk("in_frame", o_inf, 32'(m_if[ci]));
    chk("frame_num", o_fn, 32'(m_fn[ci]));
    if (!ok || !long_pkt || wc == 16'd0) begin
      chk("short_done", o_done, 32'd1);
      chk("short_pv", o_pv, 32'd0);
    end else begin
      chk("hdr_done", o_done, 32'd0);
      chk("hdr_in_line", o_inl, 32'(fwd));
      nbeats = (int'(wc) + nl - 1) / nl;
      for (int k = 0; k < nbeats; k++) begin
        if ($urandom_range(3, 0) == 0) begin
          drive($urandom, 1'b0);
          chk("stall_pv", o_pv, 32'd0);
          chk("stall_done", o_done, 32'd0);
        end
        d    = $urandom;
        cnt  = int'(wc) - k * nl;
        if (cnt > nl) cnt = nl;
        last = (k == nbeats - 1);
        drive(d, 1'b1);
        exp_be = fwd ? 4'((1 << cnt) - 1) : 4'h0;
        msk    = fwd ? bmask(cnt) : 32'hFFFF_FFFF;
        exp_d  = fwd ? (d & msk) : 32'h0;
        beat_chk(32'(fwd), exp_d, msk, 32'(exp_be), 32'(fwd && last), 32'(last), 32'(fwd));
        if (k == freeze_at) begin
          enable = 1'b0;
          for (int r = 0; r < 5; r++) begin
            drive($urandom, 1'b1);
            beat_chk(32'(fwd), exp_d, msk, 32'(exp_be), 32'(fwd && last), 32'(last), 32'(fwd));
          end
          enable = 1'b1;
        end
      end
    end
    if (fwd && m_if[ci] && m_ln[ci] != 16'hFFFF) m_ln[ci] = m_ln[ci] + 16'd1;
    drive(32'h0, 1'b0);
    chk("stop_done", o_done, 32'd0);
    chk("stop_herr", o_herr, 32'd0);
    chk("stop_in_line", o_inl, 32'd0);
    chk("stop_line_num", o_ln, 32'(m_ln[ci]));
    chk("stop_in_frame", o_inf, 32'(m_if[ci]));
    drive(32'h0, 1'b0);
    chk("back_idle", o_sync, 32'd1);
  endtask

  initial begin
    logic [5:0]  dts [13];
    logic [7:0]  h [4];
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
    int          nl;
    n_asrt    = 0;
    n_fail    = 0;
    reset     = 1'b1;
    enable    = 1'b1;
    drv_data  = '0;
    drv_valid = 1'b0;
    sel       = 2;
    for (int i = 0; i < 2; i++) begin
      m_if[i] = 1'b0;
      m_fn[i] = '0;
      m_ln[i] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    sel = 2;
    chk_reset("rst2");
    sel = 4;
    chk_reset("rst4");
    reset = 1'b0;
    drive(32'h0, 1'b0);

    // Directed packets from the plan.
    send_pkt(2, 2'd0, 6'h00, 16'd5, 1'b0, -1);
    send_pkt(2, 2'd0, 6'h2B, 16'd7, 1'b0, -1);
    send_pkt(4, 2'd1, 6'h00, 16'd3, 1'b0, -1);
    send_pkt(4, 2'd1, 6'h2A, 16'd6, 1'b0, -1);
    send_pkt(4, 2'd2, 6'h2A, 16'd10, 1'b0, -1);
    send_pkt(2, 2'd0, 6'h2B, 16'd16, 1'b1, -1);
    send_pkt(2, 2'd0, 6'h2B, 16'd9000, 1'b0, -1);
    send_pkt(2, 2'd0, 6'h2C, 16'd12, 1'b0, 2);

    // Random packets on both instances.
    dts = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h10, 6'h12, 6'h2A, 6'h2B, 6'h2D, 6'h28, 6'h05,
            6'h20, 6'h3F};
    for (int p = 0; p < 40; p++) begin
      nl = ($urandom_range(1, 0) == 0) ? 2 : 4;
      dt = dts[$urandom_range(12, 0)];
      vc = ($urandom_range(1, 0) == 0) ? ((nl == 2) ? 2'd0 : 2'd1) : 2'($urandom_range(3, 0));
      if (dt < 6'h10) wc = 16'($urandom_range(65535, 0));
      else if ($urandom_range(9, 0) == 0) wc = 16'd9000;
      else wc = 16'($urandom_range(24, 1));
      send_pkt(nl, vc, dt, wc, $urandom_range(7, 0) == 0, -1);
    end

    // Reset in the middle of a forwarded RAW packet.
    send_pkt(2, 2'd0, 6'h00, 16'd9, 1'b0, -1);
    sel  = 2;
    h[0] = {2'd0, 6'h2B};
    h[1] = 8'd20;
    h[2] = 8'd0;
    h[3] = ref_ecc({h[2], h[1], h[0]});
    drive({16'h0, h[1], h[0]}, 1'b1);
    drive({16'h0, h[3], h[2]}, 1'b1);
    drive($urandom, 1'b1);
    drive($urandom, 1'b1);
    chk("pre_reset_pv", o_pv, 32'd1);
    chk("pre_reset_inf", o_inf, 32'd1);
    drv_data = $urandom;
    #2;
    reset = 1'b1;
    #1;
    chk_reset("mid_rst");
    for (int i = 0; i < 2; i++) begin
      m_if[i] = 1'b0;
      m_fn[i] = '0;
      m_ln[i] = '0;
    end
    drive(32'h0, 1'b0);
    reset = 1'b0;
    drive(32'h0, 1'b0);
    send_pkt(2, 2'd0, 6'h00, 16'd42, 1'b0, -1);
    send_pkt(2, 2'd0, 6'h2B, 16'd5, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
